// File: rtl/sprite_obj.sv
// ============================================================================
// Module   : sprite_obj
// Brief    : One hardware sprite: pixel RAM with a streaming loader, double-
//            buffered position/shape/attributes, and a per-pixel scan hit path.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sprite_obj #(
    parameter int SIZE_LOG2 = 3,
    parameter int COLOR_W   = 24,
    parameter int COORD_W   = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [COORD_W-1:0]              scan_x,
    input  logic [COORD_W-1:0]              scan_y,
    input  logic                            active,
    input  logic                            frame_start,
    input  logic                            pos_we,
    input  logic [COORD_W-1:0]              pos_x,
    input  logic [COORD_W-1:0]              pos_y,
    input  logic                            shape_we,
    input  logic [(1<<(2*SIZE_LOG2))-1:0]   shape,
    input  logic                            attr_we,
    input  logic                            flip_h,
    input  logic                            flip_v,
    input  logic [1:0]                      scale_log2,
    input  logic                            ld_start,
    input  logic                            ld_valid,
    input  logic [COLOR_W-1:0]              ld_data,
    output logic                            ld_ready,
    output logic                            ld_done,
    output logic                            hit,
    output logic [COLOR_W-1:0]              pix
);

    localparam int              N      = 1 << SIZE_LOG2;
    localparam int              NPIX   = N * N;
    localparam int              AW     = 2 * SIZE_LOG2;
    localparam logic [AW-1:0]   C_LAST = AW'(NPIX - 1);
    localparam logic [COORD_W:0] C_N_EXT = (COORD_W + 1)'(N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [AW-1:0]          r_addr;
    logic                   r_ready;
    logic                   r_done;
    logic                   w_wr;

    logic [COLOR_W-1:0]     r_mem [NPIX];

    logic [COORD_W-1:0]     r_sh_x, r_sh_y, r_cur_x, r_cur_y;
    logic [NPIX-1:0]        r_sh_shape, r_cur_shape;
    logic                   r_sh_fh, r_sh_fv, r_cur_fh, r_cur_fv;
    logic [1:0]             r_sh_scale, r_cur_scale;

    logic [1:0]             w_scale;
    logic [COORD_W:0]       w_foot;
    logic [COORD_W:0]       w_dx, w_dy;
    logic                   w_in_x, w_in_y;
    logic [SIZE_LOG2-1:0]   w_col_raw, w_row_raw, w_col, w_row;
    logic [AW-1:0]          w_raddr;
    logic                   w_hit;

    logic                   r_hit;
    logic [COLOR_W-1:0]     r_pix;

    // Load FSM: ld_ready is a registered copy of "state is LOAD".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ld_start) begin
                        r_state <= ST_LOAD;
                        r_addr  <= '0;
                        r_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_start) begin
                        r_addr <= '0;
                    end else if (ld_valid) begin
                        if (r_addr == C_LAST) begin
                            r_state <= ST_IDLE;
                            r_addr  <= '0;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // A restart beat is dropped so the new stream begins cleanly at address 0.
    assign w_wr = r_ready & ld_valid & ~ld_start;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_x      <= '0;
            r_sh_y      <= '0;
            r_sh_shape  <= '0;
            r_sh_fh     <= 1'b0;
            r_sh_fv     <= 1'b0;
            r_sh_scale  <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_cur_shape <= '0;
            r_cur_fh    <= 1'b0;
            r_cur_fv    <= 1'b0;
            r_cur_scale <= '0;
        end else begin
            if (pos_we) begin
                r_sh_x <= pos_x;
                r_sh_y <= pos_y;
            end
            if (shape_we) begin
                r_sh_shape <= shape;
            end
            if (attr_we) begin
                r_sh_fh    <= flip_h;
                r_sh_fv    <= flip_v;
                r_sh_scale <= scale_log2;
            end
            // Writes landing on the commit cycle bypass the shadow copy.
            if (frame_start) begin
                r_cur_x     <= pos_we   ? pos_x      : r_sh_x;
                r_cur_y     <= pos_we   ? pos_y      : r_sh_y;
                r_cur_shape <= shape_we ? shape      : r_sh_shape;
                r_cur_fh    <= attr_we  ? flip_h     : r_sh_fh;
                r_cur_fv    <= attr_we  ? flip_v     : r_sh_fv;
                r_cur_scale <= attr_we  ? scale_log2 : r_sh_scale;
            end
        end
    end

    // Offsets use one extra bit so a sprite near the right/bottom edge never wraps.
    assign w_scale   = (r_cur_scale == 2'd3) ? 2'd2 : r_cur_scale;
    assign w_foot    = C_N_EXT << w_scale;
    assign w_dx      = {1'b0, scan_x} - {1'b0, r_cur_x};
    assign w_dy      = {1'b0, scan_y} - {1'b0, r_cur_y};
    assign w_in_x    = (scan_x >= r_cur_x) && (w_dx < w_foot);
    assign w_in_y    = (scan_y >= r_cur_y) && (w_dy < w_foot);
    assign w_col_raw = SIZE_LOG2'(w_dx >> w_scale);
    assign w_row_raw = SIZE_LOG2'(w_dy >> w_scale);
    assign w_col     = r_cur_fh ? ~w_col_raw : w_col_raw;
    assign w_row     = r_cur_fv ? ~w_row_raw : w_row_raw;
    assign w_raddr   = {w_row, w_col};
    assign w_hit     = w_in_x & w_in_y & r_cur_shape[w_raddr] & active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit <= 1'b0;
            r_pix <= '0;
        end else begin
            r_hit <= w_hit;
            r_pix <= w_hit ? r_mem[w_raddr] : '0;
        end
    end

    assign hit      = r_hit;
    assign pix      = r_pix;
    assign ld_ready = r_ready;
    assign ld_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_obj.sv
// ============================================================================
// Module   : tb_sprite_obj
// Brief    : Directed self-checking bench for sprite_obj with a scan scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sprite_obj;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  scan_x = '0, scan_y = '0;
    logic        active = 1'b0, frame_start = 1'b0;
    logic        pos_we = 1'b0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic        shape_we = 1'b0;
    logic [63:0] shape = '0;
    logic        attr_we = 1'b0, flip_h = 1'b0, flip_v = 1'b0;
    logic [1:0]  scale_log2 = '0;
    logic        ld_start = 1'b0, ld_valid = 1'b0;
    logic [23:0] ld_data = '0;
    logic        ld_ready, ld_done, hit;
    logic [23:0] pix;

    int          n_checks = 0;
    int          n_err = 0;
    logic [23:0] tb_mem [64];
    logic        q_hit [$];
    logic [23:0] q_pix [$];
    int          dones;

    sprite_obj #(.SIZE_LOG2(3), .COLOR_W(24), .COORD_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .scan_x(scan_x), .scan_y(scan_y),
        .active(active), .frame_start(frame_start),
        .pos_we(pos_we), .pos_x(pos_x), .pos_y(pos_y),
        .shape_we(shape_we), .shape(shape),
        .attr_we(attr_we), .flip_h(flip_h), .flip_v(flip_v), .scale_log2(scale_log2),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done), .hit(hit), .pix(pix)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one scan coordinate; its registered result is checked a cycle later.
    task automatic scan(input string tag, input int x, input int y,
                        input logic eh, input logic [23:0] ep);
        logic       oh;
        logic [23:0] op;
        @(negedge clk);
        scan_x = 10'(x);
        scan_y = 10'(y);
        q_hit.push_back(eh);
        q_pix.push_back(ep);
        @(posedge clk);
        #1;
        oh = q_hit.pop_front();
        op = q_pix.pop_front();
        chk({tag, "_hit"}, 32'(hit), 32'(oh));
        chk({tag, "_pix"}, 32'(pix), 32'(op));
    endtask

    task automatic wr_shadow(input bit wp, input int x, input int y,
                             input bit ws, input logic [63:0] s,
                             input bit wa, input bit fh, input bit fv, input int sc,
                             input bit fs);
        @(negedge clk);
        pos_we = wp; pos_x = 10'(x); pos_y = 10'(y);
        shape_we = ws; shape = s;
        attr_we = wa; flip_h = fh; flip_v = fv; scale_log2 = 2'(sc);
        frame_start = fs;
        @(negedge clk);
        pos_we = 1'b0; shape_we = 1'b0; attr_we = 1'b0; frame_start = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Full 64-beat load; the start pulse carries a valid beat that must be dropped.
    task automatic do_load(input string tag, input int base, input bit toggle);
        int   acc = 0;
        int   cyc = 0;
        int   rdy_low = 0;
        logic rdy;
        dones = 0;
        @(negedge clk);
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 24'hDEAD00;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        chk({tag, "_ready_start"}, 32'(ld_ready), 32'd1);
        while (acc < 64 && cyc < 400) begin
            if (cyc != 0) @(negedge clk);
            ld_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            ld_data  = 24'(base + acc);
            rdy = ld_ready;
            if (!rdy) rdy_low++;
            @(posedge clk);
            if (ld_valid && rdy) begin
                tb_mem[acc] = 24'(base + acc);
                acc++;
            end
            #1;
            if (ld_done) dones++;
            cyc++;
        end
        chk({tag, "_accepted"}, 32'(acc), 32'd64);
        chk({tag, "_ready_low_during"}, 32'(rdy_low), 32'd0);
        chk({tag, "_ready_after"}, 32'(ld_ready), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        if (ld_done) dones++;
        chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
        chk({tag, "_done_low"}, 32'(ld_done), 32'd0);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #9;
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_pix", 32'(pix), 32'd0);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_done", 32'(ld_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        active = 1'b1;
        scan("rst_invisible", 0, 0, 1'b0, 24'h0);

        do_load("load1", 1, 1'b1);

        wr_shadow(1, 100, 50, 1, {64{1'b1}}, 1, 0, 0, 0, 0);
        scan("pre_commit", 103, 52, 1'b0, 24'h0);
        commit();
        scan("basic_hit", 103, 52, 1'b1, 24'h000014);
        scan("right_edge", 108, 50, 1'b0, 24'h0);
        scan("left_edge", 99, 50, 1'b0, 24'h0);
        scan("corner", 107, 57, 1'b1, tb_mem[63]);
        active = 1'b0;
        scan("inactive", 103, 52, 1'b0, 24'h0);
        active = 1'b1;

        wr_shadow(1, 200, 50, 0, '0, 0, 0, 0, 0, 0);
        scan("shadow_only_old", 103, 52, 1'b1, tb_mem[19]);
        scan("shadow_only_new", 200, 50, 1'b0, 24'h0);
        commit();
        scan("moved_new", 200, 50, 1'b1, tb_mem[0]);
        scan("moved_old", 103, 52, 1'b0, 24'h0);
        wr_shadow(1, 100, 50, 0, '0, 0, 0, 0, 0, 1);
        scan("writethrough", 100, 50, 1'b1, tb_mem[0]);

        wr_shadow(0, 0, 0, 0, '0, 1, 1, 0, 1, 1);
        scan("flip_scale", 101, 50, 1'b1, tb_mem[7]);
        scan("scale_last", 115, 50, 1'b1, tb_mem[0]);
        scan("scale_out", 116, 50, 1'b0, 24'h0);
        wr_shadow(0, 0, 0, 0, '0, 1, 0, 0, 3, 1);
        scan("scale3_in", 131, 50, 1'b1, tb_mem[7]);
        scan("scale3_out", 132, 50, 1'b0, 24'h0);
        scan("scale3_y", 100, 81, 1'b1, tb_mem[56]);
        wr_shadow(0, 0, 0, 0, '0, 1, 0, 1, 0, 1);
        scan("flip_v", 100, 50, 1'b1, tb_mem[56]);

        wr_shadow(1, 636, 50, 1, {{63{1'b1}}, 1'b0}, 1, 0, 0, 0, 1);
        scan("no_wrap", 2, 50, 1'b0, 24'h0);
        scan("screen_edge", 639, 50, 1'b1, tb_mem[3]);
        wr_shadow(1, 100, 50, 0, '0, 0, 0, 0, 0, 1);
        scan("shape_bit0", 100, 50, 1'b0, 24'h0);
        scan("shape_bit1", 101, 50, 1'b1, tb_mem[1]);

        // Abandon a load partway through with an asynchronous reset.
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 29; i++) begin
            ld_data = 24'(32'h100 + i);
            @(negedge clk);
            tb_mem[i] = 24'(32'h100 + i);
        end
        ld_data = 24'h00011D;
        chk("midload_hit_before", 32'(hit), 32'd1);
        chk("midload_ready_before", 32'(ld_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ld_ready), 32'd0);
        chk("midrst_hit", 32'(hit), 32'd0);
        chk("midrst_pix", 32'(pix), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ld_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (ld_done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_idle", 32'(ld_ready), 32'd0);
        scan("midrst_invisible", 101, 50, 1'b0, 24'h0);
        wr_shadow(1, 100, 50, 1, {64{1'b1}}, 0, 0, 0, 0, 1);
        scan("ram_kept", 100, 55, 1'b1, tb_mem[40]);
        scan("ram_partial", 100, 50, 1'b1, 24'h000100);

        // Restart while still loading: a few beats, then a fresh start pulse.
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ld_data = 24'(32'h300 + i);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        do_load("reload", 32'h200, 1'b0);
        scan("reload_first", 100, 50, 1'b1, 24'h000200);
        scan("reload_second", 101, 50, 1'b1, 24'h000201);
        scan("reload_last", 107, 57, 1'b1, 24'h00023F);

        chk("scoreboard_empty", 32'(q_hit.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
